// File: rtl/mem_arbiter.sv
// Two-requester arbiter (instruction fetch vs. data) for a single-port, fixed-latency memory.
// One transaction is in flight at a time; data has priority unless fetch has been starved.
module mem_arbiter #(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,

  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,

  output logic        mem_en,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,

  output logic        busy
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } arbStateT;

  localparam logic [2:0] LAT_LOAD   = 3'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  arbStateT   state, stateNext;
  logic [2:0] waitCnt, waitCntNext;
  logic [3:0] starveCnt, starveCntNext;
  logic       ownerData, ownerDataNext;
  logic       ownerStore, ownerStoreNext;
  logic       grantF, grantD, respDone;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      waitCnt    <= 3'd0;
      starveCnt  <= 4'd0;
      ownerData  <= 1'b0;
      ownerStore <= 1'b0;
    end else begin
      state      <= stateNext;
      waitCnt    <= waitCntNext;
      starveCnt  <= starveCntNext;
      ownerData  <= ownerDataNext;
      ownerStore <= ownerStoreNext;
    end
  end

  // Grant and response decisions are suppressed entirely while reset is held.
  always_comb begin
    stateNext      = state;
    waitCntNext    = waitCnt;
    starveCntNext  = starveCnt;
    ownerDataNext  = ownerData;
    ownerStoreNext = ownerStore;
    grantF         = 1'b0;
    grantD         = 1'b0;
    respDone       = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (if_req || d_req) begin
            if (if_req && (!d_req || starveCnt == STARVE_LIM)) begin
              grantF        = 1'b1;
              starveCntNext = 4'd0;
            end else begin
              grantD = 1'b1;
              if (if_req && starveCnt < STARVE_LIM) begin
                starveCntNext = starveCnt + 4'd1;
              end
            end
            ownerDataNext  = grantD;
            ownerStoreNext = grantD && d_we;
            waitCntNext    = LAT_LOAD;
            stateNext      = WAIT;
          end
        end
        WAIT: begin
          if (waitCnt == 3'd0) begin
            respDone  = 1'b1;
            stateNext = IDLE;
          end else begin
            waitCntNext = waitCnt - 3'd1;
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  // Memory port carries a request only in the grant cycle and is zeroed otherwise.
  always_comb begin
    if_gnt    = grantF;
    d_gnt     = grantD;
    mem_en    = grantF || grantD;
    mem_we    = grantD && d_we;
    mem_be    = 4'b0000;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    if (grantF) begin
      mem_be   = 4'b1111;
      mem_addr = if_addr;
    end else if (grantD) begin
      mem_be    = d_we ? d_be : 4'b1111;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end
  end

  // Store acknowledgements strobe d_rvalid but never return data.
  always_comb begin
    if_rvalid = respDone && !ownerData;
    d_rvalid  = respDone && ownerData;
    if_rdata  = if_rvalid ? mem_rdata : 32'd0;
    d_rdata   = (d_rvalid && !ownerStore) ? mem_rdata : 32'd0;
    busy      = !rst && (state == WAIT);
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (MEM_LAT=2 and MEM_LAT=1) checked every cycle against
// a transaction-level model, plus directed scenarios with hand-computed literal expectations.
module tb_mem_arbiter;

  localparam int STARVE_MAX = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        ifReq [2];
  logic [31:0] ifAddr [2];
  logic        dReq [2];
  logic        dWe [2];
  logic [3:0]  dBe [2];
  logic [31:0] dAddr [2];
  logic [31:0] dWdata [2];
  logic [31:0] memRdata [2];

  logic        ifGnt [2];
  logic        ifRvalid [2];
  logic [31:0] ifRdata [2];
  logic        dGnt [2];
  logic        dRvalid [2];
  logic [31:0] dRdata [2];
  logic        memEn [2];
  logic        memWe [2];
  logic [3:0]  memBe [2];
  logic [31:0] memAddr [2];
  logic [31:0] memWdata [2];
  logic        busy [2];

  int total = 0;
  int bad   = 0;

  for (genvar g = 0; g < 2; g++) begin : gDut
    mem_arbiter #(.MEM_LAT(g == 0 ? 2 : 1), .STARVE_MAX(STARVE_MAX)) dut (
      .clk(clk), .rst(rst),
      .if_req(ifReq[g]), .if_addr(ifAddr[g]), .if_gnt(ifGnt[g]),
      .if_rvalid(ifRvalid[g]), .if_rdata(ifRdata[g]),
      .d_req(dReq[g]), .d_we(dWe[g]), .d_be(dBe[g]), .d_addr(dAddr[g]), .d_wdata(dWdata[g]),
      .d_gnt(dGnt[g]), .d_rvalid(dRvalid[g]), .d_rdata(dRdata[g]),
      .mem_en(memEn[g]), .mem_we(memWe[g]), .mem_be(memBe[g]), .mem_addr(memAddr[g]),
      .mem_wdata(memWdata[g]), .mem_rdata(memRdata[g]),
      .busy(busy[g])
    );
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int latOf(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  // Transaction-level model: a busy flag with the absolute cycle of the response.
  int ncyc = 0;
  bit mBusy [2];
  int mResp [2];
  bit mOwnerData [2];
  bit mOwnerStore [2];
  int mStarve [2];

  task automatic modelCycle(input int k);
    logic        eIfGnt = 0, eDGnt = 0, eMemEn = 0, eMemWe = 0, eIfRv = 0, eDRv = 0, eBusy = 0;
    logic [3:0]  eMemBe = 0;
    logic [31:0] eMemAddr = 0, eMemWdata = 0, eIfRdata = 0, eDRdata = 0;
    bit          fetchWins;
    if (rst) begin
      mBusy[k]   = 0;
      mStarve[k] = 0;
    end else if (mBusy[k]) begin
      eBusy = 1;
      if (ncyc == mResp[k]) begin
        if (mOwnerData[k]) begin
          eDRv    = 1;
          eDRdata = mOwnerStore[k] ? 32'd0 : memRdata[k];
        end else begin
          eIfRv    = 1;
          eIfRdata = memRdata[k];
        end
        mBusy[k] = 0;
      end
    end else if (ifReq[k] || dReq[k]) begin
      fetchWins = ifReq[k] && (!dReq[k] || mStarve[k] == STARVE_MAX);
      eMemEn = 1;
      if (fetchWins) begin
        eIfGnt = 1;
        eMemAddr = ifAddr[k];
        eMemBe = 4'hF;
        mStarve[k] = 0;
        mOwnerData[k] = 0;
      end else begin
        eDGnt = 1;
        eMemAddr = dAddr[k];
        eMemWe = dWe[k];
        eMemBe = dWe[k] ? dBe[k] : 4'hF;
        eMemWdata = dWdata[k];
        if (ifReq[k] && mStarve[k] < STARVE_MAX) mStarve[k]++;
        mOwnerData[k] = 1;
        mOwnerStore[k] = dWe[k];
      end
      mBusy[k] = 1;
      mResp[k] = ncyc + latOf(k);
    end
    checkOutput($sformatf("u%0d.if_gnt", k), ifGnt[k], eIfGnt);
    checkOutput($sformatf("u%0d.d_gnt", k), dGnt[k], eDGnt);
    checkOutput($sformatf("u%0d.mem_en", k), memEn[k], eMemEn);
    checkOutput($sformatf("u%0d.mem_we", k), memWe[k], eMemWe);
    checkOutput($sformatf("u%0d.mem_be", k), memBe[k], eMemBe);
    checkOutput($sformatf("u%0d.mem_addr", k), memAddr[k], eMemAddr);
    checkOutput($sformatf("u%0d.mem_wdata", k), memWdata[k], eMemWdata);
    checkOutput($sformatf("u%0d.if_rvalid", k), ifRvalid[k], eIfRv);
    checkOutput($sformatf("u%0d.if_rdata", k), ifRdata[k], eIfRdata);
    checkOutput($sformatf("u%0d.d_rvalid", k), dRvalid[k], eDRv);
    checkOutput($sformatf("u%0d.d_rdata", k), dRdata[k], eDRdata);
    checkOutput($sformatf("u%0d.busy", k), busy[k], eBusy);
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) modelCycle(k);
    ncyc++;
  end

  task automatic applyStimulus(input int k, input logic fq, input logic [31:0] fa,
                               input logic dq, input logic we, input logic [3:0] be,
                               input logic [31:0] da, input logic [31:0] wd);
    ifReq[k]  = fq;
    ifAddr[k] = fa;
    dReq[k]   = dq;
    dWe[k]    = we;
    dBe[k]    = be;
    dAddr[k]  = da;
    dWdata[k] = wd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    memRdata[0] = $urandom;
    memRdata[1] = $urandom;
  endtask

  task automatic settle();
    #2;
  endtask

  string seq;

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      applyStimulus(k, 0, 0, 0, 0, 0, 0, 0);
      memRdata[k] = 0;
    end

    // Reset holds everything quiet even with a request present.
    step(); applyStimulus(0, 1, 32'h10, 0, 0, 0, 0, 0); settle();
    checkOutput("rst_if_gnt", ifGnt[0], 0);
    checkOutput("rst_mem_en", memEn[0], 0);
    checkOutput("rst_busy", busy[0], 0);

    // Lone fetch, MEM_LAT=2.
    step(); rst = 1'b0; settle();
    checkOutput("f_gnt", ifGnt[0], 1);
    checkOutput("f_mem_en", memEn[0], 1);
    checkOutput("f_mem_addr", memAddr[0], 32'h10);
    checkOutput("f_mem_be", memBe[0], 4'hF);
    step(); applyStimulus(0, 0, 0, 0, 0, 0, 0, 0); settle();
    checkOutput("f_busy1", busy[0], 1);
    checkOutput("f_gnt_wait", ifGnt[0], 0);
    step(); memRdata[0] = 32'h1234_5678; settle();
    checkOutput("f_rvalid", ifRvalid[0], 1);
    checkOutput("f_rdata", ifRdata[0], 32'h1234_5678);
    checkOutput("f_busy2", busy[0], 1);
    step(); settle();
    checkOutput("f_idle_busy", busy[0], 0);
    checkOutput("f_idle_rdata", ifRdata[0], 0);

    // Both request: store wins, fetch follows at cycle 3.
    step(); applyStimulus(0, 1, 32'h40, 1, 1, 4'b0100, 32'h22, 32'hDEAD_BEEF); settle();
    checkOutput("st_d_gnt", dGnt[0], 1);
    checkOutput("st_if_gnt", ifGnt[0], 0);
    checkOutput("st_mem_we", memWe[0], 1);
    checkOutput("st_mem_be", memBe[0], 4'b0100);
    checkOutput("st_mem_addr", memAddr[0], 32'h22);
    checkOutput("st_mem_wdata", memWdata[0], 32'hDEAD_BEEF);
    step(); applyStimulus(0, 1, 32'h40, 0, 0, 0, 0, 0); settle();
    checkOutput("st_no_gnt", {31'd0, dGnt[0] | ifGnt[0]}, 0);
    step(); memRdata[0] = 32'hFFFF_FFFF; settle();
    checkOutput("st_d_rvalid", dRvalid[0], 1);
    checkOutput("st_d_rdata", dRdata[0], 0);
    step(); settle();
    checkOutput("st_then_if_gnt", ifGnt[0], 1);
    checkOutput("st_then_addr", memAddr[0], 32'h40);
    step(); applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    step(); step();

    // Continuous contention: fetch forced every STARVE_MAX data grants.
    seq = "";
    for (int i = 0; i < 30; i++) begin
      step();
      if (i == 0) applyStimulus(0, 1, 32'h80, 1, 0, 4'hF, 32'h84, 0);
      settle();
      if (dGnt[0]) seq = {seq, "D"};
      if (ifGnt[0]) seq = {seq, "F"};
    end
    total++;
    if (seq != "DDDDFDDDDF") begin
      bad++;
      $display("[TB] FAIL grant_seq: got %s expected DDDDFDDDDF", seq);
    end
    step(); applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    step(); step();

    // Reset during WAIT abandons the load; pending fetch wins right after reset.
    step(); applyStimulus(0, 0, 0, 1, 0, 4'hF, 32'h88, 0); settle();
    checkOutput("ra_d_gnt", dGnt[0], 1);
    step(); applyStimulus(0, 1, 32'h90, 0, 0, 0, 0, 0); rst = 1'b1; settle();
    checkOutput("ra_rst_busy", busy[0], 0);
    checkOutput("ra_rst_gnt", ifGnt[0], 0);
    step(); rst = 1'b0; settle();
    checkOutput("ra_if_gnt", ifGnt[0], 1);
    checkOutput("ra_no_drv1", dRvalid[0], 0);
    checkOutput("ra_busy", busy[0], 0);
    step(); applyStimulus(0, 0, 0, 0, 0, 0, 0, 0); settle();
    checkOutput("ra_no_drv2", dRvalid[0], 0);
    step(); settle();
    checkOutput("ra_if_rvalid", ifRvalid[0], 1);
    step();

    // MEM_LAT=1 instance: back-to-back loads, grant/response alternate.
    seq = "";
    for (int i = 0; i < 6; i++) begin
      step();
      if (i == 0) applyStimulus(1, 0, 0, 1, 0, 4'b0011, 32'h100, 32'h55);
      if (i == 5) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
      settle();
      if (i == 0) checkOutput("l1_mem_be", memBe[1], 4'hF);
      if (dGnt[1] && dRvalid[1]) seq = {seq, "X"};
      else if (dGnt[1]) seq = {seq, "G"};
      else if (dRvalid[1]) seq = {seq, "R"};
      else seq = {seq, "-"};
    end
    total++;
    if (seq != "GRGRGR") begin
      bad++;
      $display("[TB] FAIL lat1_seq: got %s expected GRGRGR", seq);
    end
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
